// File: rtl/cv32e40p_fault_pkg.sv
// Shared types and constants for the fault monitor slice.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package cv32e40p_fault_pkg;

    // Interrupt handshake states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        ACKED = 2'd2
    } fsm_state_e;

    // Channels 4..6 carry the register-file double-error and similar
    // uncorrectable indications in the default core wiring.
    localparam logic [31:0] DEFAULT_UNCORR_MASK = 32'h0000_0070;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cv32e40p_fault_ch.sv
// One fault channel: rising-edge detect, saturating counter, sticky/sat, clear.
// Latency: event sampled at edge k is visible on cnt/sticky/sat in cycle k+1.
// Backpressure: none; fault_i is sampled every cycle.
module cv32e40p_fault_ch #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             fault_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] threshold_i,
    output logic             evt_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sticky_o,
    output logic             sat_o,
    output logic             thr_hit_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             prev;
    logic [CNT_W-1:0] cnt_nxt;

    // The previous level is tracked even while disabled, so a level that is
    // already high when monitoring is enabled does not count.
    assign evt_o = fault_i & ~prev & en_i;

    // Next counter value; an event in the same cycle as a clear wins.
    always_comb begin
        cnt_nxt = cnt_o;
        if (evt_o) begin
            if (clr_i)                cnt_nxt = CNT_W'(1);
            else if (cnt_o != CNT_MAX) cnt_nxt = cnt_o + 1'b1;
        end else if (clr_i) begin
            cnt_nxt = '0;
        end
    end

    // Threshold crossing only on the cycle the count moves onto it, so a
    // threshold change or a saturated counter never raises a fresh hit.
    assign thr_hit_o = (threshold_i != '0) && (cnt_nxt == threshold_i) &&
                       (cnt_o != threshold_i);

    // Channel state: sticky and sat follow the event/clear outcome together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev     <= 1'b0;
            cnt_o    <= '0;
            sticky_o <= 1'b0;
            sat_o    <= 1'b0;
        end else begin
            prev <= fault_i;
            if (evt_o || clr_i) begin
                cnt_o    <= cnt_nxt;
                sticky_o <= evt_o;
                sat_o    <= evt_o && (cnt_nxt == CNT_MAX);
            end
        end
    end

endmodule

// File: rtl/cv32e40p_fault_monitor.sv
// Fault-event monitor: per-channel counters, alarm level and interrupt handshake.
// Latency: counters/alarm change in cycle k+1 after edge k; irq_o registered, rises in k+1.
// Backpressure: none; a trigger while an interrupt is pending is absorbed.
module cv32e40p_fault_monitor
    import cv32e40p_fault_pkg::*;
#(
    parameter int                NUM_CH      = 8,
    parameter int                CNT_W       = 8,
    parameter logic [NUM_CH-1:0] UNCORR_MASK = NUM_CH'(DEFAULT_UNCORR_MASK),
    parameter int                CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] fault_i,
    input  logic [CNT_W-1:0]  threshold_i,
    input  logic              clr_i,
    input  logic [NUM_CH-1:0] clr_mask_i,
    input  logic [CH_W-1:0]   cnt_sel_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [NUM_CH-1:0] sticky_o,
    output logic [NUM_CH-1:0] sat_o,
    output logic              alarm_o,
    output logic              irq_o,
    output logic [CH_W-1:0]   irq_id_o,
    input  logic              irq_ack_i
);

    localparam int SEL_N = 2 ** CH_W;

    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] thr_hit;
    logic [NUM_CH-1:0] clr_ch;
    logic [NUM_CH-1:0] trig;
    logic [CNT_W-1:0]  cnt_pad [SEL_N];
    logic [CH_W-1:0]   trig_id;
    logic              thr_ge;
    fsm_state_e        state;

    assign clr_ch = clr_mask_i & {NUM_CH{clr_i}};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cv32e40p_fault_ch #(.CNT_W(CNT_W)) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .en_i        (en_i),
            .fault_i     (fault_i[g]),
            .clr_i       (clr_ch[g]),
            .threshold_i (threshold_i),
            .evt_o       (evt[g]),
            .cnt_o       (cnt_pad[g]),
            .sticky_o    (sticky_o[g]),
            .sat_o       (sat_o[g]),
            .thr_hit_o   (thr_hit[g])
        );
    end

    // Unused select codes read back as zero.
    for (genvar g = NUM_CH; g < SEL_N; g++) begin : g_pad
        assign cnt_pad[g] = '0;
    end

    assign cnt_o = cnt_pad[cnt_sel_i];

    // A channel that stays saturated cannot trigger again, uncorrectable or
    // not; a clear in the same cycle lifts that block.
    assign trig = thr_hit | (evt & UNCORR_MASK & ~(sat_o & ~clr_ch));

    // Lowest-index triggering channel.
    always_comb begin
        trig_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (trig[i]) trig_id = CH_W'(i);
        end
    end

    // Any counter at or above the common threshold.
    always_comb begin
        thr_ge = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_pad[i] >= threshold_i) thr_ge = 1'b1;
        end
    end

    assign alarm_o = (|(sticky_o & UNCORR_MASK)) | ((threshold_i != '0) & thr_ge);

    // Interrupt handshake; a trigger coinciding with the ack is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            irq_o    <= 1'b0;
            irq_id_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|trig) begin
                        state    <= PEND;
                        irq_o    <= 1'b1;
                        irq_id_o <= trig_id;
                    end
                end
                PEND: begin
                    if (irq_ack_i) begin
                        state <= ACKED;
                        irq_o <= 1'b0;
                    end
                end
                ACKED: begin
                    if (|trig) begin
                        state    <= PEND;
                        irq_o    <= 1'b1;
                        irq_id_o <= trig_id;
                    end else if (!alarm_o) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_fault_monitor.sv
// Bench for the fault monitor: directed steps, then random traffic vs a reference model.
// Latency: outputs compared 1 time unit after every rising clock edge.
// Backpressure: n/a.
module tb_cv32e40p_fault_monitor;

    localparam int          NCH  = 8;
    localparam int          CW   = 4;
    localparam int          MAXC = (1 << CW) - 1;
    localparam bit [NCH-1:0] UNC = 8'h70;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic [NCH-1:0]  fault = '0;
    logic [CW-1:0]   thr = '0;
    logic            clr = 1'b0;
    logic [NCH-1:0]  clr_mask = '0;
    logic [2:0]      sel = '0;
    logic            ack = 1'b0;
    logic [CW-1:0]   cnt_o;
    logic [NCH-1:0]  sticky;
    logic [NCH-1:0]  sat;
    logic            alarm;
    logic            irq;
    logic [2:0]      irq_id;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: plain counts and flags per channel.
    int              m_cnt [NCH];
    bit [NCH-1:0]    m_prev, m_sticky, m_sat;
    bit              m_pend, m_acked;
    int              m_id;

    cv32e40p_fault_monitor #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .fault_i     (fault),
        .threshold_i (thr),
        .clr_i       (clr),
        .clr_mask_i  (clr_mask),
        .cnt_sel_i   (sel),
        .cnt_o       (cnt_o),
        .sticky_o    (sticky),
        .sat_o       (sat),
        .alarm_o     (alarm),
        .irq_o       (irq),
        .irq_id_o    (irq_id),
        .irq_ack_i   (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
        m_prev = '0; m_sticky = '0; m_sat = '0;
        m_pend = 0; m_acked = 0; m_id = 0;
    endtask

    function automatic bit m_alarm();
        bit a = 0;
        for (int i = 0; i < NCH; i++) begin
            if (UNC[i] && m_sticky[i]) a = 1;
            if (thr != 0 && m_cnt[i] >= int'(thr)) a = 1;
        end
        return a;
    endfunction

    // Apply the rules of one clock edge to the model, using the inputs in force.
    task automatic model_edge();
        bit a_now, any;
        int low, nc;
        a_now = m_alarm();
        any = 0; low = 0;
        for (int i = 0; i < NCH; i++) begin
            bit evt, c;
            evt = fault[i] && !m_prev[i] && en;
            c   = clr && clr_mask[i];
            if (evt) begin
                nc = (c ? 0 : m_cnt[i]) + 1;
                if (nc > MAXC) nc = MAXC;
                if (!(m_sat[i] && !c) &&
                    (UNC[i] || (thr != 0 && nc == int'(thr) && m_cnt[i] != int'(thr)))) begin
                    if (!any) low = i;
                    any = 1;
                end
                m_cnt[i] = nc; m_sticky[i] = 1; m_sat[i] = (nc == MAXC);
            end else if (c) begin
                m_cnt[i] = 0; m_sticky[i] = 0; m_sat[i] = 0;
            end
            m_prev[i] = fault[i];
        end
        if (m_pend) begin
            if (ack) begin m_pend = 0; m_acked = 1; end
        end else if (any) begin
            m_pend = 1; m_acked = 0; m_id = low;
        end else if (m_acked && !a_now) begin
            m_acked = 0;
        end
    endtask

    task automatic check_all();
        check("cnt_o", 32'(cnt_o), 32'(m_cnt[sel]));
        check("sticky_o", 32'(sticky), 32'(m_sticky));
        check("sat_o", 32'(sat), 32'(m_sat));
        check("alarm_o", 32'(alarm), 32'(m_alarm()));
        check("irq_o", 32'(irq), 32'(m_pend));
        check("irq_id_o", 32'(irq_id), 32'(m_id));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pulse(input int ch);
        fault[ch] = 1'b1; step();
        fault[ch] = 1'b0; step();
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cnt", 32'(cnt_o), 0);
        check("rst_sticky", 32'(sticky), 0);
        check("rst_sat", 32'(sat), 0);
        check("rst_alarm", 32'(alarm), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_irq_id", 32'(irq_id), 0);
        rst = 1'b0;
        en  = 1'b1;

        // Correctable pulse on ch0 with thresholds disabled
        sel = 3'd0; thr = 0;
        fault[0] = 1'b1; step();
        check("t1_cnt", 32'(cnt_o), 1);
        check("t1_sticky", 32'(sticky), 32'h01);
        check("t1_alarm", 32'(alarm), 0);
        check("t1_irq", 32'(irq), 0);
        fault[0] = 1'b0; step();

        // Threshold 3 crossing on ch2, ack, then clear back to idle
        thr = 3; sel = 3'd2;
        pulse(2); pulse(2);
        check("t2_noirq", 32'(irq), 0);
        fault[2] = 1'b1; step();
        check("t2_irq", 32'(irq), 1);
        check("t2_id", 32'(irq_id), 2);
        fault[2] = 1'b0;
        ack = 1'b1; step(); ack = 1'b0;
        check("t2_ack_irq", 32'(irq), 0);
        check("t2_alarm", 32'(alarm), 1);
        step();
        clr = 1'b1; clr_mask = 8'h04; step(); clr = 1'b0;
        check("t2_clr_cnt", 32'(cnt_o), 0);
        check("t2_clr_alarm", 32'(alarm), 0);
        step();

        // Simultaneous ch5 (uncorrectable) and ch6 events; then a held level
        thr = 0; sel = 3'd5;
        fault[5] = 1'b1; fault[6] = 1'b1; step();
        check("t3_irq", 32'(irq), 1);
        check("t3_id", 32'(irq_id), 5);
        fault[6] = 1'b0;
        repeat (10) step();
        check("t3_held_cnt", 32'(cnt_o), 1);
        fault[5] = 1'b0; step();
        ack = 1'b1; step(); ack = 1'b0;

        // Re-trigger from ACKED, then ack colliding with a trigger
        fault[6] = 1'b1; step();
        check("t5_pend_id", 32'(irq_id), 6);
        fault[6] = 1'b0; step();
        ack = 1'b1; fault[5] = 1'b1; step();
        check("t5_ack_irq", 32'(irq), 0);
        ack = 1'b0; fault[5] = 1'b0; step();
        check("t5_dropped", 32'(irq), 0);
        check("t5_alarm", 32'(alarm), 1);
        fault[4] = 1'b1; step();
        check("t5_ch4_irq", 32'(irq), 1);
        check("t5_ch4_id", 32'(irq_id), 4);
        fault[4] = 1'b0; step();

        // Saturation on ch1, then clear colliding with an event
        ack = 1'b1; step(); ack = 1'b0;
        sel = 3'd1;
        repeat (MAXC + 5) pulse(1);
        check("t4_sat_cnt", 32'(cnt_o), MAXC);
        check("t4_sat_bit", 32'(sat[1]), 1);
        clr = 1'b1; clr_mask = 8'h02; fault[1] = 1'b1; step();
        clr = 1'b0; fault[1] = 1'b0;
        check("t4_clr_evt_cnt", 32'(cnt_o), 1);
        check("t4_clr_evt_sat", 32'(sat[1]), 0);
        step();

        // Level that rises while disabled must not count
        sel = 3'd3;
        en = 1'b0; fault[3] = 1'b1; step();
        en = 1'b1; step(); step();
        check("t6_cnt", 32'(cnt_o), 0);
        check("t6_sticky", 32'(sticky[3]), 0);
        fault[3] = 1'b0; step();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < NCH; b++)
                if ($urandom_range(0, 3) == 0) fault[b] = ~fault[b];
            en       = ($urandom_range(0, 15) != 0);
            clr      = ($urandom_range(0, 19) == 0);
            clr_mask = NCH'($urandom);
            ack      = ($urandom_range(0, 7) == 0);
            sel      = 3'($urandom);
            if (n % 100 == 0) thr = CW'($urandom);
            step();
        end

        // Asynchronous reset while an interrupt is pending
        fault = '0; en = 1'b1; ack = 1'b0;
        clr = 1'b1; clr_mask = 8'hFF; step(); clr = 1'b0;
        ack = 1'b1; step(); ack = 1'b0;
        sel = 3'd4;
        fault[4] = 1'b1; step();
        check("t7_irq", 32'(irq), 1);
        check("t7_id", 32'(irq_id), 4);
        fault[4] = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t7_rst_irq", 32'(irq), 0);
        check("t7_rst_cnt", 32'(cnt_o), 0);
        check("t7_rst_sticky", 32'(sticky), 0);
        check("t7_rst_alarm", 32'(alarm), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
